// File: rtl/adder_bist_pkg.sv
// ============================================================================
// adder_bist_pkg: shared types, constants and xorshift64 step for the adder BIST
// Rev 1.0
// ============================================================================
`default_nettype none

package adder_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CORNER = 3'd1,
        ST_RANDOM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam int          NUM_CORNER = 8;
    localparam logic [15:0] FAIL_NONE  = 16'hFFFF;

    function automatic logic [63:0] xorshift64(input logic [63:0] x);
        logic [63:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 7);
        y = y ^ (y << 17);
        return y;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adder_bist_xorshift64.sv
// ============================================================================
// adder_bist_xorshift64: seed-loadable 64-bit xorshift generator; next_o is the
// value the state takes at this edge, so a load+step yields step(SEED) at once.
// Rev 1.0
// ============================================================================
`default_nettype none

module adder_bist_xorshift64
    import adder_bist_pkg::*;
#(
    parameter logic [63:0] SEED = 64'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        step_i,
    output logic [63:0] next_o
);

    logic [63:0] state_q;
    logic [63:0] state_d;
    logic [63:0] w_base;

    always_comb begin
        w_base  = load_i ? SEED : state_q;
        state_d = step_i ? xorshift64(w_base) : w_base;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign next_o = state_d;

endmodule

`default_nettype wire

// File: rtl/adder_bist_ctrl.sv
// ============================================================================
// adder_bist_ctrl: BIST controller driving corner + xorshift vectors into an
// adder and checking {cout,sum} after DUT_LAT cycles. Macro: ADDER_BIST_CORNER_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module adder_bist_ctrl
    import adder_bist_pkg::*;
#(
    parameter int          WIDTH      = 32,
    parameter int          DUT_LAT    = 1,
    parameter int          NUM_RANDOM = 1024,
    parameter logic [63:0] SEED_A     = 64'h9E37_79B9_7F4A_7C15,
    parameter logic [63:0] SEED_B     = 64'hD1B5_4A32_D192_ED03
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] dut_a,
    output logic [WIDTH-1:0] dut_b,
    output logic             dut_cin,
    input  logic [WIDTH-1:0] dut_sum,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic             passed,
    output logic [15:0]      err_count,
    output logic [15:0]      first_fail
);

`ifdef ADDER_BIST_CORNER_EN
    localparam int NUM_PRE = NUM_CORNER;
    localparam logic [63:0] PAT_A = 64'h5555_5555_5555_5555;
    localparam logic [63:0] PAT_B = 64'hAAAA_AAAA_AAAA_AAAA;

    // Packed as {a, b, cin}
    function automatic logic [2*WIDTH:0] corner_vec(input logic [2:0] k);
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] msb;
        logic [WIDTH-1:0] one;
        ones = '1;
        msb  = {1'b1, {(WIDTH-1){1'b0}}};
        one  = {{(WIDTH-1){1'b0}}, 1'b1};
        case (k)
            3'd0:    corner_vec = {{WIDTH{1'b0}}, {WIDTH{1'b0}}, 1'b0};
            3'd1:    corner_vec = {{WIDTH{1'b0}}, {WIDTH{1'b0}}, 1'b1};
            3'd2:    corner_vec = {ones, {WIDTH{1'b0}}, 1'b1};
            3'd3:    corner_vec = {ones, ones, 1'b1};
            3'd4:    corner_vec = {ones, one, 1'b0};
            3'd5:    corner_vec = {PAT_A[WIDTH-1:0], PAT_B[WIDTH-1:0], 1'b1};
            3'd6:    corner_vec = {msb, msb, 1'b0};
            default: corner_vec = {ones, ones, 1'b0};
        endcase
    endfunction
`else
    localparam int NUM_PRE = 0;
`endif

    localparam int          NUM_VEC  = NUM_PRE + NUM_RANDOM;
    localparam logic [15:0] LAST_IDX = 16'(NUM_VEC - 1);
    localparam logic [2:0]  DRN_LAST = 3'(DUT_LAT - 1);

    state_e           state_q;
    logic [15:0]      idx_q;
    logic [2:0]       drn_q;
    logic [WIDTH-1:0] dut_a_q;
    logic [WIDTH-1:0] dut_b_q;
    logic             dut_cin_q;
    logic             busy_q;
    logic             done_q;
    logic             passed_q;
    logic [15:0]      err_q;
    logic [15:0]      err_d;
    logic [15:0]      ff_q;
    logic [15:0]      ff_d;

    logic             w_start;
    logic             w_step;
    logic [63:0]      next_a;
    logic [63:0]      next_b;
    logic             w_vld;
    logic [WIDTH:0]   w_exp;
    logic             t_vld;
    logic [15:0]      t_idx;
    logic [WIDTH:0]   t_exp;
    logic             w_mis;
    logic             w_unused;

    assign w_start = start && (state_q == ST_IDLE || state_q == ST_DONE);

    always_comb begin
        w_step = 1'b0;
`ifdef ADDER_BIST_CORNER_EN
        if (state_q == ST_CORNER && idx_q[2:0] == 3'd7) w_step = 1'b1;
`else
        if (w_start) w_step = 1'b1;
`endif
        if (state_q == ST_RANDOM && idx_q != LAST_IDX) w_step = 1'b1;
    end

    adder_bist_xorshift64 #(.SEED(SEED_A)) u_gen_a (
        .clk    (clk),
        .rst    (rst),
        .load_i (w_start),
        .step_i (w_step),
        .next_o (next_a)
    );

    adder_bist_xorshift64 #(.SEED(SEED_B)) u_gen_b (
        .clk    (clk),
        .rst    (rst),
        .load_i (w_start),
        .step_i (w_step),
        .next_o (next_b)
    );

    assign w_unused = &{1'b0, next_a, next_b};

    // A vector is on the operand registers exactly while in CORNER or RANDOM
    assign w_vld = (state_q == ST_CORNER) || (state_q == ST_RANDOM);
    assign w_exp = {1'b0, dut_a_q} + {1'b0, dut_b_q} + {{WIDTH{1'b0}}, dut_cin_q};

    generate
        if (DUT_LAT == 0) begin : g_lat0
            assign t_vld = w_vld;
            assign t_idx = idx_q;
            assign t_exp = w_exp;
        end else begin : g_dly
            logic [DUT_LAT-1:0] dv_q;
            logic [15:0]        di_q [DUT_LAT];
            logic [WIDTH:0]     de_q [DUT_LAT];

            always_ff @(posedge clk) begin
                if (rst || w_start) begin
                    dv_q <= '0;
                end else begin
                    dv_q[0] <= w_vld;
                    for (int k = 1; k < DUT_LAT; k++) dv_q[k] <= dv_q[k-1];
                end
                di_q[0] <= idx_q;
                de_q[0] <= w_exp;
                for (int k = 1; k < DUT_LAT; k++) begin
                    di_q[k] <= di_q[k-1];
                    de_q[k] <= de_q[k-1];
                end
            end

            assign t_vld = dv_q[DUT_LAT-1];
            assign t_idx = di_q[DUT_LAT-1];
            assign t_exp = de_q[DUT_LAT-1];
        end
    endgenerate

    assign w_mis = t_vld && ({dut_cout, dut_sum} != t_exp);

    always_comb begin
        err_d = err_q;
        ff_d  = ff_q;
        if (w_start) begin
            err_d = 16'd0;
            ff_d  = FAIL_NONE;
        end else if (w_mis) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (ff_q == FAIL_NONE) ff_d = t_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= 16'd0;
            drn_q     <= 3'd0;
            dut_a_q   <= '0;
            dut_b_q   <= '0;
            dut_cin_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            passed_q  <= 1'b0;
            err_q     <= 16'd0;
            ff_q      <= FAIL_NONE;
        end else begin
            err_q <= err_d;
            ff_q  <= ff_d;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        idx_q    <= 16'd0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        passed_q <= 1'b0;
`ifdef ADDER_BIST_CORNER_EN
                        state_q <= ST_CORNER;
                        {dut_a_q, dut_b_q, dut_cin_q} <= corner_vec(3'd0);
`else
                        state_q   <= ST_RANDOM;
                        dut_a_q   <= next_a[WIDTH-1:0];
                        dut_b_q   <= next_b[WIDTH-1:0];
                        dut_cin_q <= next_a[63] ^ next_b[63];
`endif
                    end
                end
`ifdef ADDER_BIST_CORNER_EN
                ST_CORNER: begin
                    idx_q <= idx_q + 16'd1;
                    if (idx_q[2:0] == 3'd7) begin
                        state_q   <= ST_RANDOM;
                        dut_a_q   <= next_a[WIDTH-1:0];
                        dut_b_q   <= next_b[WIDTH-1:0];
                        dut_cin_q <= next_a[63] ^ next_b[63];
                    end else begin
                        {dut_a_q, dut_b_q, dut_cin_q} <= corner_vec(3'(idx_q[2:0] + 3'd1));
                    end
                end
`endif
                ST_RANDOM: begin
                    if (idx_q == LAST_IDX) begin
                        drn_q <= 3'd0;
                        if (DUT_LAT == 0) begin
                            state_q  <= ST_DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            passed_q <= (err_d == 16'd0);
                        end else begin
                            state_q <= ST_DRAIN;
                        end
                    end else begin
                        idx_q     <= idx_q + 16'd1;
                        dut_a_q   <= next_a[WIDTH-1:0];
                        dut_b_q   <= next_b[WIDTH-1:0];
                        dut_cin_q <= next_a[63] ^ next_b[63];
                    end
                end
                ST_DRAIN: begin
                    if (drn_q == DRN_LAST) begin
                        state_q  <= ST_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        passed_q <= (err_d == 16'd0);
                    end else begin
                        drn_q <= drn_q + 3'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dut_a      = dut_a_q;
    assign dut_b      = dut_b_q;
    assign dut_cin    = dut_cin_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign passed     = passed_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;

endmodule

`default_nettype wire
